// File: rtl/seq_pattern_detector_if.sv
// Bus bundle for the serial pattern detector: serial input, configuration,
// counter clear, and status outputs. Clock and reset stay as plain ports.
interface seq_pattern_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               i_sequence;
  logic               i_seq_valid;
  logic               i_cfg_load;
  logic [LEN_W-1:0]   i_cfg_len;
  logic [MAX_LEN-1:0] i_cfg_pattern;
  logic               i_count_clr;
  logic               o_tick;
  logic [CNT_W-1:0]   o_match_count;
  logic               o_armed;
  logic               o_cfg_err;

  modport slave (
    input  i_sequence, i_seq_valid, i_cfg_load, i_cfg_len, i_cfg_pattern, i_count_clr,
    output o_tick, o_match_count, o_armed, o_cfg_err
  );

  modport master (
    output i_sequence, i_seq_valid, i_cfg_load, i_cfg_len, i_cfg_pattern, i_count_clr,
    input  o_tick, o_match_count, o_armed, o_cfg_err
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with overlap/non-overlap
// modes, gapped input, run-time reconfiguration and a saturating match count.
module seq_pattern_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 DEF_LEN     = 5,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b00010001,
  parameter bit                 OVERLAP     = 1'b1,
  parameter int                 CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_pattern_detector_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Sparse one-hot style codes leave illegal encodings that recover to FILL.
  typedef enum logic [1:0] {
    FILL = 2'b01,
    HUNT = 2'b10
  } state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill_cnt;
  logic [LEN_W-1:0]   r_len;
  logic [MAX_LEN-1:0] r_pat;
  logic               r_tick;
  logic [CNT_W-1:0]   r_count;
  logic               r_armed;
  logic               r_cfg_err;

  state_t             w_state_nxt;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic [MAX_LEN-1:0] w_hist_shift;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic               w_match;
  logic               w_cfg_ok;

  assign w_cfg_ok     = bus.i_cfg_load && (bus.i_cfg_len != '0)
                        && (bus.i_cfg_len <= LEN_W'(MAX_LEN));
  assign w_hist_shift = {r_hist[MAX_LEN-2:0], bus.i_sequence};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) w_mask[i] = (i < int'(r_len));
  end

  assign w_hit = (((w_hist_shift ^ r_pat) & w_mask) == '0);

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill_cnt;
    w_match     = 1'b0;
    if (w_cfg_ok) begin
      w_state_nxt = FILL;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
    end else begin
      case (r_state)
        FILL: begin
          if (bus.i_seq_valid) begin
            w_hist_nxt = w_hist_shift;
            if ((r_fill_cnt + LEN_W'(1)) == r_len) begin
              w_state_nxt = HUNT;
              w_match     = w_hit;
            end else begin
              w_fill_nxt = r_fill_cnt + LEN_W'(1);
            end
          end
        end
        HUNT: begin
          if (bus.i_seq_valid) begin
            w_hist_nxt = w_hist_shift;
            w_match    = w_hit;
          end
        end
        default: begin
          w_state_nxt = FILL;
          w_fill_nxt  = '0;
        end
      endcase
      // Non-overlapping mode restarts the search from an empty history.
      if (w_match && !OVERLAP) begin
        w_state_nxt = FILL;
        w_hist_nxt  = '0;
        w_fill_nxt  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FILL;
      r_hist     <= '0;
      r_fill_cnt <= '0;
      r_len      <= LEN_W'(DEF_LEN);
      r_pat      <= DEF_PATTERN;
      r_tick     <= 1'b0;
      r_count    <= '0;
      r_armed    <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hist     <= w_hist_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_tick     <= w_match;
      r_armed    <= (w_state_nxt == HUNT);
      r_cfg_err  <= bus.i_cfg_load && !w_cfg_ok;
      if (w_cfg_ok) begin
        r_len <= bus.i_cfg_len;
        r_pat <= bus.i_cfg_pattern;
      end
      if (bus.i_count_clr) begin
        r_count <= '0;
      end else if (w_match && !(&r_count)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.o_tick        = r_tick;
  assign bus.o_match_count = r_count;
  assign bus.o_armed       = r_armed;
  assign bus.o_cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomized and directed bench for seq_pattern_detector: three instances
// (overlap, non-overlap, 2-bit counter) checked against a queue-based model.
module tb_seq_pattern_detector;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(16)) bus0 ();
  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(16)) bus1 ();
  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(2))  bus2 ();

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .OVERLAP(1'b1), .CNT_W(16)) dut_ov (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .OVERLAP(1'b0), .CNT_W(16)) dut_nov (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  int n_checks   = 0;
  int n_failures = 0;

  // Reference model: the valid bits seen since the last clear, newest last.
  bit         q_ov[$];
  bit         q_nov[$];
  int         m_len;
  logic [7:0] m_pat;
  int         m_cnt_ov, m_cnt_nov, m_cnt_sat;
  bit         m_tick_ov, m_tick_nov, m_err;
  int         n_tick_ov, n_tick_nov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit tail_matches(input bit q[$], input int len, input logic [7:0] pat);
    if (q.size() < len) return 1'b0;
    for (int k = 0; k < len; k++)
      if (q[q.size() - len + k] != pat[len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input bit s, input bit v, input bit ld, input logic [LEN_W-1:0] l,
                       input logic [7:0] p, input bit clr);
    bus0.i_sequence = s;  bus1.i_sequence = s;  bus2.i_sequence = s;
    bus0.i_seq_valid = v; bus1.i_seq_valid = v; bus2.i_seq_valid = v;
    bus0.i_cfg_load = ld; bus1.i_cfg_load = ld; bus2.i_cfg_load = ld;
    bus0.i_cfg_len = l;   bus1.i_cfg_len = l;   bus2.i_cfg_len = l;
    bus0.i_cfg_pattern = p; bus1.i_cfg_pattern = p; bus2.i_cfg_pattern = p;
    bus0.i_count_clr = clr; bus1.i_count_clr = clr; bus2.i_count_clr = clr;
  endtask

  task automatic check_outputs();
    check("tick_ov",  32'(bus0.o_tick), 32'(m_tick_ov));
    check("tick_nov", 32'(bus1.o_tick), 32'(m_tick_nov));
    check("tick_sat", 32'(bus2.o_tick), 32'(m_tick_ov));
    check("cnt_ov",   32'(bus0.o_match_count), 32'(m_cnt_ov));
    check("cnt_nov",  32'(bus1.o_match_count), 32'(m_cnt_nov));
    check("cnt_sat",  32'(bus2.o_match_count), 32'(m_cnt_sat));
    check("armed_ov",  32'(bus0.o_armed), 32'(q_ov.size() >= m_len));
    check("armed_nov", 32'(bus1.o_armed), 32'(q_nov.size() >= m_len));
    check("cfg_err",  32'(bus0.o_cfg_err), 32'(m_err));
    check("cfg_err_nov", 32'(bus1.o_cfg_err), 32'(m_err));
  endtask

  task automatic cycle(input bit s, input bit v, input bit ld, input logic [LEN_W-1:0] l,
                       input logic [7:0] p, input bit clr);
    bit accept;
    drive(s, v, ld, l, p, clr);
    m_err      = ld && !(l >= 1 && l <= MAX_LEN);
    accept     = ld && !m_err;
    m_tick_ov  = 1'b0;
    m_tick_nov = 1'b0;
    if (accept) begin
      m_len = int'(l);
      m_pat = p;
      q_ov.delete();
      q_nov.delete();
    end else if (v) begin
      q_ov.push_back(s);
      if (q_ov.size() > MAX_LEN) void'(q_ov.pop_front());
      q_nov.push_back(s);
      if (q_nov.size() > MAX_LEN) void'(q_nov.pop_front());
      m_tick_ov  = tail_matches(q_ov, m_len, m_pat);
      m_tick_nov = tail_matches(q_nov, m_len, m_pat);
      if (m_tick_nov) q_nov.delete();
    end
    if (clr) begin
      m_cnt_ov = 0; m_cnt_nov = 0; m_cnt_sat = 0;
    end else begin
      if (m_tick_ov && m_cnt_ov < 65535) m_cnt_ov++;
      if (m_tick_nov && m_cnt_nov < 65535) m_cnt_nov++;
      if (m_tick_ov && m_cnt_sat < 3) m_cnt_sat++;
    end
    @(posedge clk);
    #1;
    check_outputs();
    if (bus0.o_tick) n_tick_ov++;
    if (bus1.o_tick) n_tick_nov++;
  endtask

  task automatic do_reset(input bit s, input bit v);
    reset = 1'b1;
    drive(s, v, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_ov.delete(); q_nov.delete();
    m_len = 5; m_pat = 8'b00010001;
    m_cnt_ov = 0; m_cnt_nov = 0; m_cnt_sat = 0;
    m_tick_ov = 1'b0; m_tick_nov = 1'b0; m_err = 1'b0;
    check_outputs();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(bits[i], 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    do_reset(1'b1, 1'b1);

    // Default pattern 10001, overlapping stream.
    n_tick_ov = 0;
    send_bits(16'b1_0001_0001, 9);
    check("dflt_ticks", 32'(n_tick_ov), 32'd2);
    check("dflt_cnt", 32'(bus0.o_match_count), 32'd2);

    // len=3 pat=101 on 10101: two overlapping hits, one non-overlapping.
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 4'd3, 8'b101, 1'b0);
    n_tick_ov = 0; n_tick_nov = 0;
    send_bits(16'b10101, 5);
    check("ov_ticks", 32'(n_tick_ov), 32'd2);
    check("nov_ticks", 32'(n_tick_nov), 32'd1);

    // Gapped input: no tick during idle cycles.
    do_reset(1'b0, 1'b0);
    n_tick_ov = 0;
    for (int b = 0; b < 3; b++) begin
      cycle(b == 0, 1'b1, 1'b0, '0, '0, 1'b0);
      for (int g = 0; g < 3; g++) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    send_bits(16'b01, 2);
    check("gap_ticks", 32'(n_tick_ov), 32'd1);

    // Illegal lengths rejected while detection of 10001 continues.
    do_reset(1'b0, 1'b0);
    n_tick_ov = 0;
    cycle(1'b1, 1'b1, 1'b1, 4'd0, 8'hff, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 4'd9, 8'hff, 1'b0);
    send_bits(16'b001, 3);
    check("rej_ticks", 32'(n_tick_ov), 32'd1);

    // Length-1 pattern: every 1 ticks; 2-bit counter saturates at 3.
    do_reset(1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'd1, 8'b1, 1'b0);
    send_bits(16'b11111, 5);
    check("sat_cnt", 32'(bus2.o_match_count), 32'd3);
    cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    check("clr_wins", 32'(bus2.o_match_count), 32'd0);

    // Mid-pattern reset discards the partial match.
    do_reset(1'b0, 1'b0);
    send_bits(16'b1000, 4);
    do_reset(1'b1, 1'b1);
    n_tick_ov = 0;
    send_bits(16'b1, 1);
    check("rst_no_tick", 32'(n_tick_ov), 32'd0);
    check("rst_armed", 32'(bus0.o_armed), 32'd0);

    // Random traffic with occasional reconfiguration, clears and resets.
    for (int n = 0; n < 4000; n++) begin
      bit               v, ld, clr;
      logic [LEN_W-1:0] l;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1'($urandom), 1'($urandom));
      end else begin
        v   = ($urandom_range(0, 3) != 0);
        ld  = ($urandom_range(0, 39) == 0);
        clr = ($urandom_range(0, 59) == 0);
        l   = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                          : LEN_W'($urandom_range(1, 4));
        cycle(1'($urandom), v, ld, l, 8'($urandom), clr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached=1 expected=0");
    $fatal(1, "bench timeout");
  end
endmodule
